// File: rtl/shift_add_datapath.sv
// shift_add_datapath: shift-and-add unsigned multiplier driven by LD/SH/D strobes with protocol checking
module shift_add_datapath #(
  parameter int WIDTH = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         LD,
  input  logic                         SH,
  input  logic                         D,
  input  logic [WIDTH-1:0]             MCAND,
  input  logic [WIDTH-1:0]             MPLIER,
  output logic [2*WIDTH-1:0]           PRODUCT,
  output logic                         VALID,
  output logic                         BUSY,
  output logic                         ERR,
  output logic [$clog2(WIDTH+1)-1:0]   STEP_CNT
);
  localparam int CW = $clog2(WIDTH+1);
  logic [WIDTH-1:0] m, q;
  logic [WIDTH:0] a, sum;
  logic [CW-1:0] cnt;
  logic run, ready;
  // partial-product adder and state decode from BUSY/cnt
  always_comb begin
    sum = a + {1'b0, q[0] ? m : {WIDTH{1'b0}}};
    run = BUSY && cnt < CW'(WIDTH);
    ready = BUSY && cnt == CW'(WIDTH);
  end
  // strobe handling with priority RST > LD > D > SH
  always_ff @(posedge CLK) begin
    if (RST) begin
      m <= '0;
      q <= '0;
      a <= '0;
      cnt <= '0;
      PRODUCT <= '0;
      VALID <= 1'b0;
      BUSY <= 1'b0;
      ERR <= 1'b0;
    end else if (LD) begin
      m <= MCAND;
      q <= MPLIER;
      a <= '0;
      cnt <= '0;
      BUSY <= 1'b1;
      VALID <= 1'b0;
      ERR <= 1'b0;
    end else if (D) begin
      if (ready) begin
        PRODUCT <= {a[WIDTH-1:0], q};
        VALID <= 1'b1;
        BUSY <= 1'b0;
        cnt <= '0;
      end else if (run) begin
        BUSY <= 1'b0;
        ERR <= 1'b1;
      end
    end else if (SH) begin
      if (run) begin
        {a, q} <= {sum, q} >> 1;
        cnt <= cnt + 1'b1;
      end else begin
        ERR <= 1'b1;
      end
    end
  end
  assign STEP_CNT = cnt;
endmodule

// File: tb/tb_shift_add_datapath.sv
// tb_shift_add_datapath: random and directed checking of shift_add_datapath against an operation-level model
module tb_shift_add_datapath;
  localparam int W = 4;
  localparam int CW = 3;
  logic clk = 1'b0;
  logic rst = 1'b0, ld = 1'b0, sh = 1'b0, d = 1'b0;
  logic [W-1:0] mcand = '0, mplier = '0;
  logic [2*W-1:0] product;
  logic valid, busy, err;
  logic [CW-1:0] step_cnt;
  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;
  int e_a, e_b, e_steps, e_prod;
  bit e_busy, e_valid, e_err;

  shift_add_datapath #(.WIDTH(W)) dut (
    .CLK(clk), .RST(rst), .LD(ld), .SH(sh), .D(d),
    .MCAND(mcand), .MPLIER(mplier),
    .PRODUCT(product), .VALID(valid), .BUSY(busy), .ERR(err), .STEP_CNT(step_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // operation-level model: counts steps and forms the product arithmetically
  always @(posedge clk) begin
    if (rst) begin
      armed = 1'b1;
      e_a = 0; e_b = 0; e_steps = 0; e_prod = 0;
      e_busy = 0; e_valid = 0; e_err = 0;
    end else if (ld) begin
      e_a = int'(mcand); e_b = int'(mplier); e_steps = 0;
      e_busy = 1; e_valid = 0; e_err = 0;
    end else if (d) begin
      if (e_busy && e_steps == W) begin
        e_prod = (e_a * e_b) & 8'hFF; e_valid = 1; e_busy = 0; e_steps = 0;
      end else if (e_busy) begin
        e_busy = 0; e_err = 1;
      end
    end else if (sh) begin
      if (e_busy && e_steps < W) e_steps++;
      else e_err = 1;
    end
    #1;
    if (armed) begin
      chk("model_product", 32'(product), 32'(e_prod));
      chk("model_valid", 32'(valid), 32'(e_valid));
      chk("model_busy", 32'(busy), 32'(e_busy));
      chk("model_err", 32'(err), 32'(e_err));
      chk("model_step_cnt", 32'(step_cnt), 32'(e_steps));
    end
  end

  task automatic drive(input logic r, input logic l, input logic s, input logic dd,
                       input logic [W-1:0] mc, input logic [W-1:0] mp);
    @(negedge clk);
    rst = r; ld = l; sh = s; d = dd; mcand = mc; mplier = mp;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, $urandom, $urandom);
  endtask

  task automatic full_op(input logic [W-1:0] mc, input logic [W-1:0] mp);
    drive(0, 1, 0, 0, mc, mp);
    repeat (W) drive(0, 0, 1, 0, $urandom, $urandom);
    drive(0, 0, 0, 1, $urandom, $urandom);
    idle();
  endtask

  task automatic chk_result(input string name, input logic [7:0] exp);
    chk({name, "_product"}, 32'(product), 32'(exp));
    chk({name, "_valid"}, 32'(valid), 32'd1);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    drive(1, $urandom, $urandom, $urandom, $urandom, $urandom);
    drive(1, $urandom, $urandom, $urandom, $urandom, $urandom);
    idle();
    chk("reset_product", 32'(product), 32'd0);
    chk("reset_flags", {29'd0, valid, busy, err}, 32'd0);
    chk("reset_step_cnt", 32'(step_cnt), 32'd0);
    drive(0, 1, 0, 0, 4'd13, 4'd11);
    for (int i = 0; i < W; i++) begin
      drive(0, 0, 1, 0, $urandom, $urandom);
      chk("nom_step", 32'(step_cnt), 32'(i));
    end
    drive(0, 0, 0, 1, $urandom, $urandom);
    chk("nom_step4", 32'(step_cnt), 32'd4);
    idle();
    chk_result("nom", 8'h8F);
    chk("nom_step_end", 32'(step_cnt), 32'd0);
    full_op(4'd15, 4'd15); chk_result("c15x15", 8'hE1);
    full_op(4'd0, 4'd9); chk_result("c0x9", 8'h00);
    full_op(4'd9, 4'd0); chk_result("c9x0", 8'h00);
    full_op(4'd1, 4'd1); chk_result("c1x1", 8'h01);
    drive(0, 1, 0, 0, 4'd5, 4'd3);
    repeat (W) drive(0, 0, 1, 0, $urandom, $urandom);
    chk("extra_sh_err_before", 32'(err), 32'd0);
    drive(0, 0, 1, 0, $urandom, $urandom);
    drive(0, 0, 0, 1, $urandom, $urandom);
    chk("extra_sh_err", 32'(err), 32'd1);
    idle();
    chk("extra_sh_product", 32'(product), 32'd15);
    chk("extra_sh_valid", 32'(valid), 32'd1);
    drive(0, 1, 0, 0, 4'd7, 4'd7);
    repeat (2) drive(0, 0, 1, 0, $urandom, $urandom);
    drive(0, 0, 0, 1, $urandom, $urandom);
    idle();
    chk("premature_err", 32'(err), 32'd1);
    chk("premature_valid", 32'(valid), 32'd0);
    chk("premature_busy", 32'(busy), 32'd0);
    chk("premature_product", 32'(product), 32'd15);
    drive(0, 1, 1, 0, 4'd2, 4'd3);
    idle();
    chk("ldsh_step_cnt", 32'(step_cnt), 32'd0);
    chk("ldsh_busy", 32'(busy), 32'd1);
    repeat (2) drive(0, 0, 1, 0, $urandom, $urandom);
    full_op(4'd7, 4'd6); chk_result("restart", 8'd42);
    drive(0, 1, 0, 0, 4'd13, 4'd11);
    repeat (2) drive(0, 0, 1, 0, $urandom, $urandom);
    drive(1, 0, 0, 0, $urandom, $urandom);
    idle();
    chk("midrst_product", 32'(product), 32'd0);
    chk("midrst_flags", {29'd0, valid, busy, err}, 32'd0);
    chk("midrst_step_cnt", 32'(step_cnt), 32'd0);
    drive(0, 0, 1, 0, $urandom, $urandom);
    idle();
    chk("midrst_sh_err", 32'(err), 32'd1);
    for (int i = 0; i < 150; i++) full_op($urandom, $urandom);
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 5) == 0, $urandom, $urandom);
    idle();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
